// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer
//   Double-buffered parallel-to-serial converter feeding a bit-stream
//   sequence detector. Words arrive over a valid/ready handshake into a
//   hold register; the shift register emits one bit per enabled clock.
//   The shift register reloads from the hold register on the same edge
//   that consumes the last bit, so back-to-back words stream with no gap.
//
// Ports
//   clk        in   1      clock, all state on posedge
//   rst_n      in   1      asynchronous active-low reset
//   in_data    in   WIDTH  parallel word
//   in_valid   in   1      in_data valid
//   in_ready   out  1      hold register empty
//   ser_en     in   1      downstream advance enable (0 stalls current bit)
//   ser_bit    out  1      current serial bit (registered)
//   ser_valid  out  1      ser_bit meaningful (registered)
//   word_done  out  1      one-cycle pulse after the last bit of a word
//   busy       out  1      hold register full or shifting
module seq_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ser_en,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ser_bit_q, ser_bit_d;
    logic               word_done_q, word_done_d;

    logic advance;
    logic last;
    logic accept;
    logic load;

    // Bit at the output end of a word for the configured bit order.
    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Move the next bit into the output position.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign ser_valid = (state_q == SHIFT);
    assign in_ready  = ~hold_valid_q;
    assign ser_bit   = ser_bit_q;
    assign word_done = word_done_q;
    assign busy      = hold_valid_q | ser_valid;

    assign advance = ser_valid & ser_en;
    assign last    = (cnt_q == CNT_LAST);
    assign accept  = in_valid & ~hold_valid_q;
    // Reload either from idle or on the edge that consumes the last bit,
    // which is what gives gap-free streaming.
    assign load    = hold_valid_q & (~ser_valid | (advance & last));

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        ser_bit_d    = ser_bit_q;
        word_done_d  = advance & last;

        // accept needs an empty hold, load needs a full one: never both.
        if (accept) begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
        end

        if (load) begin
            shift_d      = hold_q;
            cnt_d        = '0;
            state_d      = SHIFT;
            hold_valid_d = 1'b0;
            ser_bit_d    = out_bit(hold_q);
        end else if (advance && last) begin
            state_d   = IDLE;
            cnt_d     = '0;
            ser_bit_d = 1'b0;
        end else if (advance) begin
            shift_d   = shift_one(shift_q);
            cnt_d     = cnt_q + CNT_W'(1);
            ser_bit_d = out_bit(shift_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            ser_bit_q    <= 1'b0;
            word_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            ser_bit_q    <= ser_bit_d;
            word_done_q  <= word_done_d;
        end
    end

endmodule
